multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every entry and data port.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width, with DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL make entry 0 hardwired zero when 1 and an ordinary entry when 0.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 ra1  input  ADDR_W  read port 1 address.
REQ-009 rd1  output  WIDTH  read port 1 data.
REQ-010 ra2  input  ADDR_W  read port 2 address.
REQ-011 rd2  output  WIDTH  read port 2 data.
REQ-012 we_a  input  1  write port A enable.
REQ-013 wa_a  input  ADDR_W  write port A address.
REQ-014 wd_a  input  WIDTH  write port A data.
REQ-015 we_b  input  1  write port B enable.
REQ-016 wa_b  input  ADDR_W  write port B address.
REQ-017 wd_b  input  WIDTH  write port B data.
REQ-018 conflict  output  1  registered flag: the previous edge saw a same-address dual write.

Function
REQ-019 Storage SHALL be DEPTH entries of WIDTH bits, updated only on the rising edge of clk while reset is low.
REQ-020 On an edge with we_a=1, entry[wa_a] SHALL take wd_a; with we_b=1, entry[wa_b] SHALL take wd_b; unaddressed entries SHALL hold.
REQ-021 If we_a=we_b=1 and wa_a==wa_b, port B SHALL win; entry takes wd_b.
REQ-022 Reads SHALL be combinational: rd1 = entry[ra1], rd2 = entry[ra2], with zero added latency.
REQ-023 With BYPASS=1, a read address matching an enabled write address in the same cycle SHALL return that write data (port B over port A); with BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-024 With ZERO_REG=1, writes to address 0 SHALL be discarded, and rd1/rd2 SHALL return 0 for address 0 regardless of bypass.
REQ-025 conflict SHALL be set to 1 at an edge where we_a=we_b=1, wa_a==wa_b, and the address is not a discarded zero-register write; otherwise cleared to 0 (one-cycle pulse per colliding edge).
REQ-026 Both read ports SHALL be independent; ra1==ra2 SHALL return identical data.
REQ-027 Any X-free address in 0..DEPTH-1 SHALL be valid; no wrap or out-of-range case exists.

Reset
REQ-028 Asserting reset SHALL immediately clear every entry to 0 and conflict to 0, independent of clk.
REQ-029 While reset is high, writes SHALL be ignored and rd1/rd2 SHALL read 0, including bypass paths.
REQ-030 Reset asserted mid-operation SHALL discard any write at a coincident edge; the first write SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-031 Reset, write A addr 3 = 0xDEADBEEF, next cycle ra1=3 -> rd1=0xDEADBEEF, all other addresses read 0.
REQ-032 we_a=we_b=1, both addr 7, wd_a=0x11, wd_b=0x22 -> entry 7 = 0x22, conflict=1 for one cycle, then 0.
REQ-033 ZERO_REG=1: write 0xFFFFFFFF to addr 0 via both ports -> rd1 with ra1=0 reads 0, conflict stays 0.
REQ-034 BYPASS=1: we_a=1, wa_a=9, wd_a=0x55, ra2=9 in the same cycle -> rd2=0x55 before the edge; with BYPASS=0 -> rd2=old value (0).
REQ-035 Fill all 32 entries with value = address, then assert reset between edges -> all reads 0 immediately; a write on the edge coincident with reset is lost.
REQ-036 WIDTH=8, ADDR_W=3: write 0xA5 to addr 7 and 0x5A to addr 1 on the same edge -> both stored; conflict=0.

Source files
------------

// File: rtl/multiport_regfile.sv
// multiport_regfile
//
// Register file with two combinational read ports and two synchronous write
// ports. Port B has priority when both write ports target the same entry in
// the same cycle. Optionally, entry 0 can be a hardwired zero, and a read can
// be forwarded the data being written in the same cycle.
//
// Parameters
//   WIDTH    data width of every entry and data port
//   ADDR_W   address width; DEPTH = 2**ADDR_W entries
//   ZERO_REG 1: entry 0 reads as zero and ignores writes; 0: ordinary entry
//   BYPASS   1: a read whose address matches an enabled write returns that
//              write's data (port B over port A); 0: reads return stored data
//
// Ports
//   clk       rising-edge clock for all state
//   reset     asynchronous active-high reset; clears all entries and conflict
//   ra1/rd1   read port 1 address / data (combinational)
//   ra2/rd2   read port 2 address / data (combinational)
//   we_a/wa_a/wd_a  write port A enable / address / data
//   we_b/wa_b/wd_b  write port B enable / address / data
//   conflict  registered; 1 for one cycle after an edge where both write ports
//             wrote the same (non-discarded) address
module multiport_regfile #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  output logic [WIDTH-1:0]  rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [WIDTH-1:0]  wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [WIDTH-1:0]  wd_b,
  output logic              conflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic ZERO_EN   = (ZERO_REG != 0);
  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_a_eff;
  logic wr_b_eff;
  logic same_addr;

  // Writes aimed at a hardwired zero entry are dropped before they reach the
  // array, the forwarding path or the conflict detector.
  assign wr_a_eff  = we_a && !(ZERO_EN && (wa_a == '0));
  assign wr_b_eff  = we_b && !(ZERO_EN && (wa_b == '0));
  assign same_addr = (wa_a == wa_b);

  // Port B is written last so it wins on a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_a_eff) begin
        mem[wa_a] <= wd_a;
      end
      if (wr_b_eff) begin
        mem[wa_b] <= wd_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict <= 1'b0;
    end else begin
      conflict <= wr_a_eff && wr_b_eff && same_addr;
    end
  end

  // Read port 1: stored value, then optional forwarding (B checked last so it
  // overrides A), then forced zero for entry 0 or while reset is held.
  always_comb begin
    rd1 = mem[ra1];
    if (BYPASS_EN) begin
      if (wr_a_eff && (wa_a == ra1)) begin
        rd1 = wd_a;
      end
      if (wr_b_eff && (wa_b == ra1)) begin
        rd1 = wd_b;
      end
    end
    if (reset || (ZERO_EN && (ra1 == '0))) begin
      rd1 = '0;
    end
  end

  // Read port 2: identical structure to port 1.
  always_comb begin
    rd2 = mem[ra2];
    if (BYPASS_EN) begin
      if (wr_a_eff && (wa_a == ra2)) begin
        rd2 = wd_a;
      end
      if (wr_b_eff && (wa_b == ra2)) begin
        rd2 = wd_b;
      end
    end
    if (reset || (ZERO_EN && (ra2 == '0))) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
module tb_multiport_regfile;

  logic clk;
  logic reset;

  // Default-parameter instance (32x32, zero reg, bypass) and a BYPASS=0 twin
  // sharing the same stimulus.
  logic [4:0]  ra1, ra2, wa_a, wa_b;
  logic [31:0] wd_a, wd_b;
  logic        we_a, we_b;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        conflict, nb_conflict;

  // Narrow instance: WIDTH=8, ADDR_W=3.
  logic [2:0]  n_ra1, n_ra2, n_wa_a, n_wa_b;
  logic [7:0]  n_wd_a, n_wd_b, n_rd1, n_rd2;
  logic        n_we_a, n_we_b, n_conflict;

  int checks = 0;
  int failures = 0;

  multiport_regfile u_dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .rd1(rd1), .ra2(ra2), .rd2(rd2),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .conflict(conflict)
  );

  multiport_regfile #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .ra1(ra1), .rd1(nb_rd1), .ra2(ra2), .rd2(nb_rd2),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .conflict(nb_conflict)
  );

  multiport_regfile #(.WIDTH(8), .ADDR_W(3)) u_w8 (
    .clk(clk), .reset(reset),
    .ra1(n_ra1), .rd1(n_rd1), .ra2(n_ra2), .rd2(n_rd2),
    .we_a(n_we_a), .wa_a(n_wa_a), .wd_a(n_wd_a),
    .we_b(n_we_b), .wa_b(n_wa_b), .wd_b(n_wd_b),
    .conflict(n_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    ra1 = 0; ra2 = 0;
    tick();
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL reset_conflict got=%0b exp=0", conflict);
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%0d rd1=%h rd2=%h exp=0", i, rd1, rd2);
      end
    end
    reset = 0;
    tick();
  endtask

  task automatic test_write_read();
    we_a = 1; wa_a = 3; wd_a = 32'hDEADBEEF;
    tick();
    idle();
    ra1 = 3;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read_a3 got=%h exp=deadbeef", rd1);
    end
    for (int i = 0; i < 32; i++) begin
      ra2 = i[4:0];
      #1;
      checks++;
      if (rd2 !== ((i == 3) ? 32'hDEADBEEF : 32'h0)) begin
        failures++;
        $display("FAIL write_read_others addr=%0d got=%h", i, rd2);
      end
    end
  endtask

  task automatic test_conflict();
    we_a = 1; wa_a = 7; wd_a = 32'h11;
    we_b = 1; wa_b = 7; wd_b = 32'h22;
    tick();
    idle();
    ra1 = 7;
    #1;
    checks++;
    if (conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_pulse got=%0b exp=1", conflict);
    end
    checks++;
    if (rd1 !== 32'h22) begin
      failures++;
      $display("FAIL conflict_b_wins got=%h exp=22", rd1);
    end
    tick();
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_clear got=%0b exp=0", conflict);
    end
    // Different addresses on both ports: both land, no conflict.
    we_a = 1; wa_a = 12; wd_a = 32'hAAAA0001;
    we_b = 1; wa_b = 13; wd_b = 32'hBBBB0002;
    tick();
    idle();
    ra1 = 12; ra2 = 13;
    #1;
    checks++;
    if (rd1 !== 32'hAAAA0001 || rd2 !== 32'hBBBB0002 || conflict !== 1'b0) begin
      failures++;
      $display("FAIL dual_write rd1=%h rd2=%h conflict=%0b", rd1, rd2, conflict);
    end
  endtask

  task automatic test_zero_reg();
    we_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF;
    we_b = 1; wa_b = 0; wd_b = 32'hFFFFFFFF;
    ra1 = 0; ra2 = 0;
    #1;
    checks++;
    if (rd1 !== 32'h0 || nb_rd1 !== 32'h0) begin
      failures++;
      $display("FAIL zero_bypass rd1=%h nb_rd1=%h exp=0", rd1, nb_rd1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_stored rd1=%h rd2=%h exp=0", rd1, rd2);
    end
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL zero_conflict got=%0b exp=0", conflict);
    end
  endtask

  task automatic test_bypass();
    we_a = 1; wa_a = 9; wd_a = 32'h55;
    ra2 = 9;
    #1;
    checks++;
    if (rd2 !== 32'h55) begin
      failures++;
      $display("FAIL bypass_on got=%h exp=55", rd2);
    end
    checks++;
    if (nb_rd2 !== 32'h0) begin
      failures++;
      $display("FAIL bypass_off got=%h exp=0", nb_rd2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (nb_rd2 !== 32'h55 || rd2 !== 32'h55) begin
      failures++;
      $display("FAIL bypass_after_edge rd2=%h nb_rd2=%h exp=55", rd2, nb_rd2);
    end
    // Same-address dual write: forwarding must prefer port B.
    we_a = 1; wa_a = 10; wd_a = 32'h0A0A;
    we_b = 1; wa_b = 10; wd_b = 32'h0B0B;
    ra1 = 10;
    #1;
    checks++;
    if (rd1 !== 32'h0B0B) begin
      failures++;
      $display("FAIL bypass_b_priority got=%h exp=0b0b", rd1);
    end
    // A-only match while B writes elsewhere.
    wa_b = 11;
    #1;
    checks++;
    if (rd1 !== 32'h0A0A) begin
      failures++;
      $display("FAIL bypass_a_only got=%h exp=0a0a", rd1);
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    we_a = 1; wa_a = 4; wd_a = 32'h1;
    we_b = 1; wa_b = 4; wd_b = 32'h2;
    tick();
    wd_a = 32'h3; wd_b = 32'h4;
    tick();
    idle();
    ra1 = 4;
    #1;
    checks++;
    if (conflict !== 1'b1 || nb_rd1 !== 32'h4) begin
      failures++;
      $display("FAIL b2b_second conflict=%0b nb_rd1=%h exp=1/4", conflict, nb_rd1);
    end
    tick();
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clear got=%0b exp=0", conflict);
    end
  endtask

  task automatic test_reset_fill();
    for (int i = 0; i < 32; i++) begin
      we_a = 1; wa_a = i[4:0]; wd_a = i;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0];
      #1;
      checks++;
      if (nb_rd1 !== ((i == 0) ? 32'h0 : 32'(i))) begin
        failures++;
        $display("FAIL fill addr=%0d got=%h exp=%h", i, nb_rd1, (i == 0) ? 0 : i);
      end
    end
    // Reset between edges clears the array without a clock edge.
    #2;
    reset = 1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = i[4:0];
      #0.1;
      checks++;
      if (rd1 !== 32'h0 || nb_rd2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_async addr=%0d rd1=%h nb_rd2=%h exp=0", i, rd1, nb_rd2);
      end
    end
    // Writes and forwarding are suppressed while reset is held.
    we_a = 1; wa_a = 5; wd_a = 32'hCAFE;
    ra1 = 5;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_bypass got=%h exp=0", rd1);
    end
    tick();
    reset = 0;
    idle();
    #1;
    checks++;
    if (rd1 !== 32'h0 || nb_rd1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_write_lost rd1=%h nb_rd1=%h exp=0", rd1, nb_rd1);
    end
    we_a = 1; wa_a = 5; wd_a = 32'hCAFE;
    tick();
    idle();
    #1;
    checks++;
    if (nb_rd1 !== 32'hCAFE) begin
      failures++;
      $display("FAIL post_reset_write got=%h exp=cafe", nb_rd1);
    end
  endtask

  task automatic test_narrow();
    n_we_a = 1; n_wa_a = 7; n_wd_a = 8'hA5;
    n_we_b = 1; n_wa_b = 1; n_wd_b = 8'h5A;
    tick();
    n_we_a = 0; n_we_b = 0;
    n_ra1 = 7; n_ra2 = 1;
    #1;
    checks++;
    if (n_rd1 !== 8'hA5 || n_rd2 !== 8'h5A) begin
      failures++;
      $display("FAIL narrow_store rd1=%h rd2=%h exp=a5/5a", n_rd1, n_rd2);
    end
    checks++;
    if (n_conflict !== 1'b0) begin
      failures++;
      $display("FAIL narrow_conflict got=%0b exp=0", n_conflict);
    end
    n_ra1 = 7; n_ra2 = 7;
    #1;
    checks++;
    if (n_rd1 !== n_rd2 || n_rd2 !== 8'hA5) begin
      failures++;
      $display("FAIL narrow_same_addr rd1=%h rd2=%h exp=a5", n_rd1, n_rd2);
    end
  endtask

  initial begin
    reset = 1;
    idle();
    ra1 = 0; ra2 = 0;
    n_ra1 = 0; n_ra2 = 0; n_we_a = 0; n_we_b = 0;
    n_wa_a = 0; n_wa_b = 0; n_wd_a = 0; n_wd_b = 0;
    test_reset();
    test_write_read();
    test_conflict();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_narrow();
    test_reset_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
